skew_delay_array: RTL and testbench

SKEW_DELAY_ARRAY -- requirements
Module: skew_delay_array

---
 rtl/skew_delay_pkg.sv | 18 +
 rtl/skew_delay_line.sv | 46 ++++
 rtl/skew_delay_array.sv | 48 ++++
 tb/tb_skew_delay_array.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/skew_delay_pkg.sv
// skew_delay_pkg: shared defaults and delay arithmetic for the skew delay array
package skew_delay_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NCH   = 4;
    localparam int DEF_STEP  = 1;

    // Delay in okay=1 cycles applied to channel c.
    function automatic int chan_delay(input int c, input int nch, input int step, input int reverse);
        return ((reverse != 0) ? (nch - 1 - c) : c) * step;
    endfunction

    // Deepest channel in the array, (NCH-1)*STEP.
    function automatic int max_depth(input int nch, input int step);
        return (nch - 1) * step;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// skew_delay_line: one channel of DEPTH stages carrying {valid, data}; DEPTH=0 is a wire
module skew_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             okay,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic             busy
);

    localparam int SW = WIDTH + 1;

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ctl;
            assign unused_ctl = ^{clk, rst_n, okay};
            assign y          = x;
            assign out_valid  = in_valid & ~clear;
            assign busy       = 1'b0;
        end else begin : g_shift
            logic [DEPTH*SW-1:0] sr_q, sr_d;
            // Newest word enters the low stage; clear wins over okay, okay=0 holds everything.
            always_comb begin
                sr_d = clear ? '0 : okay ? ((sr_q << SW) | (DEPTH*SW)'({in_valid, x})) : sr_q;
            end
            // Stage register, flushed asynchronously by reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sr_q <= '0;
                else        sr_q <= sr_d;
            end
            // Busy while any stage still carries a valid word.
            always_comb begin
                busy = 1'b0;
                for (int i = 0; i < DEPTH; i++) busy = busy | sr_q[i*SW+WIDTH];
            end
            assign {out_valid, y} = sr_q[DEPTH*SW-1 -: SW];
        end
    endgenerate

endmodule

// File: rtl/skew_delay_array.sv
// skew_delay_array: per-channel staggered delay lines; SKEW_DELAY_ZERO_GATE_EN zeroes invalid output lanes
module skew_delay_array
    import skew_delay_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NCH     = DEF_NCH,
    parameter int STEP    = DEF_STEP,
    parameter int REVERSE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 okay,
    input  logic                 clear,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] x,
    output logic [NCH-1:0]       out_valid,
    output logic [NCH*WIDTH-1:0] y,
    output logic                 busy
);

    localparam int MAX_DEPTH = max_depth(NCH, STEP);

    logic [NCH-1:0] line_busy;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam int D = chan_delay(c, NCH, STEP, REVERSE);
        logic [WIDTH-1:0] y_raw;
        skew_delay_line #(.WIDTH(WIDTH), .DEPTH(D)) u_line (
            .clk       (clk),
            .rst_n     (rst_n),
            .okay      (okay),
            .clear     (clear),
            .in_valid  (in_valid[c]),
            .x         (x[c*WIDTH +: WIDTH]),
            .out_valid (out_valid[c]),
            .y         (y_raw),
            .busy      (line_busy[c])
        );
`ifdef SKEW_DELAY_ZERO_GATE_EN
        assign y[c*WIDTH +: WIDTH] = out_valid[c] ? y_raw : '0;
`else
        assign y[c*WIDTH +: WIDTH] = y_raw;
`endif
    end

    assign busy = (MAX_DEPTH > 0) && (|line_busy);

endmodule

// File: tb/tb_skew_delay_array.sv
// tb_skew_delay_array: directed and random checks of forward and reversed skew arrays against a history model
module tb_skew_delay_array;

    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n, okay, clear;
    logic [N-1:0] in_valid, ov0, ov1;
    logic [N*W-1:0] x, y0, y1;
    logic busy0, busy1;
    int checks = 0;
    int errors = 0;

    // Model: hv[k]/hx[k] is the input accepted k+1 okay edges ago (zeroed by clear/reset).
    logic [N-1:0]   hv [N];
    logic [N*W-1:0] hx [N];

    always #5 clk = ~clk;

    skew_delay_array #(.WIDTH(W), .NCH(N), .STEP(1), .REVERSE(0)) dut_fwd (
        .clk(clk), .rst_n(rst_n), .okay(okay), .clear(clear), .in_valid(in_valid),
        .x(x), .out_valid(ov0), .y(y0), .busy(busy0)
    );

    skew_delay_array #(.WIDTH(W), .NCH(N), .STEP(1), .REVERSE(1)) dut_rev (
        .clk(clk), .rst_n(rst_n), .okay(okay), .clear(clear), .in_valid(in_valid),
        .x(x), .out_valid(ov1), .y(y1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            hv[k] = '0;
            hx[k] = '0;
        end
    endtask

    function automatic void expect_out(input bit rev, output logic [N-1:0] ev, output logic [N*W-1:0] ey, output logic eb);
        ev = '0;
        ey = '0;
        eb = 1'b0;
        for (int c = 0; c < N; c++) begin
            int d;
            logic v;
            logic [W-1:0] w;
            d = rev ? (N - 1 - c) : c;
            if (d == 0) begin
                v = in_valid[c] & ~clear;
                w = x[c*W +: W];
            end else begin
                v = hv[d-1][c];
                w = hx[d-1][c*W +: W];
                for (int k = 0; k < d; k++) eb = eb | hv[k][c];
            end
`ifdef SKEW_DELAY_ZERO_GATE_EN
            if (!v) w = '0;
`endif
            ev[c] = v;
            ey[c*W +: W] = w;
        end
    endfunction

    task automatic check(input string tag);
        logic [N-1:0] ev;
        logic [N*W-1:0] ey;
        logic eb;
        expect_out(1'b0, ev, ey, eb);
        chk({tag, ".fwd_ov"}, 32'(ov0), 32'(ev));
        chk({tag, ".fwd_y"}, y0, ey);
        chk({tag, ".fwd_busy"}, 32'(busy0), 32'(eb));
        expect_out(1'b1, ev, ey, eb);
        chk({tag, ".rev_ov"}, 32'(ov1), 32'(ev));
        chk({tag, ".rev_y"}, y1, ey);
        chk({tag, ".rev_busy"}, 32'(busy1), 32'(eb));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (!rst_n || clear) model_clear();
        else if (okay) begin
            for (int k = N - 1; k > 0; k--) begin
                hv[k] = hv[k-1];
                hx[k] = hx[k-1];
            end
            hv[0] = in_valid;
            hx[0] = x;
        end
        #2 check(tag);
    endtask

    initial begin
        rst_n = 1'b0; okay = 1'b0; clear = 1'b0; in_valid = '0; x = '0;
        model_clear();
        #1 check("reset");
        chk("reset_busy", 32'(busy0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single sample walks across the lanes.
        okay = 1'b1; x = 32'h04030201; in_valid = 4'hF;
        #1 check("fwd_c0");
        chk("fwd_c0_ov", 32'(ov0), 32'h1);
        chk("rev_c0_ov", 32'(ov1), 32'h8);
        tick("fwd_e1");
        in_valid = '0; x = '0;
        #1 check("fwd_c1");
        chk("fwd_c1_ov", 32'(ov0), 32'h2);
        chk("fwd_c1_lane1", 32'(y0[15:8]), 32'h02);
        chk("fwd_c1_busy", 32'(busy0), 32'd1);
        tick("fwd_e2");
        chk("fwd_c2_lane2", 32'(y0[23:16]), 32'h03);
        tick("fwd_e3");
        chk("fwd_c3_ov", 32'(ov0), 32'h8);
        chk("fwd_c3_lane3", 32'(y0[31:24]), 32'h04);
        chk("rev_c3_ov", 32'(ov1), 32'h1);
        chk("rev_c3_lane0", 32'(y1[7:0]), 32'h01);
        tick("fwd_e4");
        chk("fwd_c4_busy", 32'(busy0), 32'd0);
        chk("fwd_c4_ov", 32'(ov0), 32'h0);

        // Stall: five okay=0 cycles push channel 3 out by five cycles.
        x = 32'hA4A3A2A1; in_valid = 4'hF; okay = 1'b1;
        tick("stall_load");
        okay = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 4'($urandom); x = $urandom;
            tick("stall_hold");
            chk("stall_hold_ov3", 32'(ov0[3]), 32'd0);
        end
        okay = 1'b1; in_valid = '0; x = '0;
        tick("stall_run1");
        tick("stall_run2");
        chk("stall_ov3", 32'(ov0[3]), 32'd1);
        chk("stall_lane3", 32'(y0[31:24]), 32'hA4);
        tick("stall_run3");

        // Clear while channels 2 and 3 still hold words.
        x = 32'hC4C3C2C1; in_valid = 4'hF;
        tick("clr_load");
        in_valid = '0; x = '0;
        tick("clr_fill");
        clear = 1'b1; okay = 1'($urandom); in_valid = 4'hF; x = $urandom;
        #1 check("clr_pre");
        chk("clr_pre_ov0", 32'(ov0[0]), 32'd0);
        tick("clr_edge");
        chk("clr_busy", 32'(busy0), 32'd0);
        chk("clr_ov", 32'(ov0), 32'h0);
        clear = 1'b0; okay = 1'b1; in_valid = '0; x = '0;
        for (int i = 0; i < 3; i++) tick("clr_after");

        // Streaming with random okay.
        for (int i = 0; i < 20; i++) begin
            in_valid = 4'hF;
            x = 32'h03020100 + 32'(i) * 32'h04040404;
            okay = 1'($urandom);
            tick("stream");
        end
        okay = 1'b1; in_valid = '0;
        for (int i = 0; i < 4; i++) tick("stream_drain");

        // Fully random traffic with occasional clears.
        for (int i = 0; i < 40; i++) begin
            in_valid = 4'($urandom); x = $urandom;
            okay = 1'($urandom); clear = ($urandom_range(0, 7) == 0);
            tick("rand");
        end
        clear = 1'b0;

        // Invalid words with all-ones data.
        okay = 1'b1; in_valid = '0; x = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) tick("gate");
`ifdef SKEW_DELAY_ZERO_GATE_EN
        chk("gate_y", y0, 32'h00000000);
`else
        chk("gate_y", y0, 32'hFFFFFFFF);
`endif

        // Asynchronous reset mid-stream, then first edge captures normally.
        in_valid = 4'hF; x = $urandom;
        tick("arst_load");
        rst_n = 1'b0;
        model_clear();
        #1 check("arst_now");
        chk("arst_busy", 32'(busy0), 32'd0);
        tick("arst_hold");
        @(negedge clk);
        rst_n = 1'b1; in_valid = 4'hF; x = 32'h5A5B5C5D;
        tick("arst_first");
        chk("arst_first_ov1", 32'(ov0[1]), 32'd1);
        chk("arst_first_lane1", 32'(y0[15:8]), 32'h5C);
        in_valid = '0;
        for (int i = 0; i < 3; i++) tick("arst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
